marquee_scroller_n: RTL

Parametrised marquee engine driving an N-digit multiplexed, active-low 7-segment display and an LED bar from a loadable message buffer. Successor to the fixed 4-digit/8-character scroller: digit count, message length and timing are parameters; the message is runtime-loadable; a bounce (ping-pong) mode is optional. Sits between board switches/buttons and the seven-segment/LED pins at top level.

---
 rtl/marquee_scroller_n.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/marquee_scroller_n.sv
`default_nettype none
// ============================================================================
// Module   : marquee_scroller_n
// Brief    : N-digit multiplexed active-low 7-segment marquee with a runtime
//            loadable message and a rotating LED bar. Optional bounce
//            (ping-pong) scrolling is compiled in by defining MARQUEE_BOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module marquee_scroller_n #(
    parameter int                     NUM_DIGITS = 4,
    parameter int                     MSG_CHARS  = 8,
    parameter int                     TICKS_SLOW = 50000000,
    parameter int                     TICKS_FAST = 25000000,
    parameter int                     MUX_TICKS  = 250000,
    parameter int                     LED_W      = 8,
    parameter logic [7*MSG_CHARS-1:0] MSG_INIT   = {MSG_CHARS{7'h7F}},
    parameter logic [LED_W-1:0]       LED_INIT   = 8'b11111000
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   EN,
    input  logic                   SPEED,
    input  logic                   DIR,
    input  logic                   MODE,
    input  logic                   LOAD,
    input  logic [7*MSG_CHARS-1:0] MSG_IN,
    output logic [6:0]             DISP,
    output logic [NUM_DIGITS-1:0]  AN,
    output logic [LED_W-1:0]       LEDs,
    output logic                   STEP
);

    localparam int c_OFS_W  = (MSG_CHARS  > 1) ? $clog2(MSG_CHARS)  : 1;
    localparam int c_SEL_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_SLOT_W = (MUX_TICKS  > 1) ? $clog2(MUX_TICKS)  : 1;
    localparam int c_SUM_W  = c_OFS_W + 1;

    localparam logic [c_OFS_W-1:0]  c_OFS_ONE   = c_OFS_W'(1);
    localparam logic [c_OFS_W-1:0]  c_OFS_LAST  = c_OFS_W'(MSG_CHARS - 1);
    localparam logic [c_SEL_W-1:0]  c_SEL_ONE   = c_SEL_W'(1);
    localparam logic [c_SEL_W-1:0]  c_SEL_LAST  = c_SEL_W'(NUM_DIGITS - 1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_ONE  = c_SLOT_W'(1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(MUX_TICKS - 1);
    localparam logic [31:0]         c_TICKS_SLOW = 32'(TICKS_SLOW);
    localparam logic [31:0]         c_TICKS_FAST = 32'(TICKS_FAST);
    localparam logic [c_SUM_W-1:0]  c_SUM_CHARS = c_SUM_W'(MSG_CHARS);
    localparam logic [c_SUM_W-1:0]  c_SUM_LEFT  = c_SUM_W'(NUM_DIGITS - 1);

    logic [7*MSG_CHARS-1:0] r_msg;
    logic [c_OFS_W-1:0]     r_ofs;
    logic [31:0]            r_tcnt;
    logic [c_SLOT_W-1:0]    r_slot;
    logic [c_SEL_W-1:0]     r_sel;
    logic [NUM_DIGITS-1:0]  r_an;
    logic [6:0]             r_disp;
    logic [LED_W-1:0]       r_leds;
    logic                   r_step;

    logic [31:0]            w_period;
    logic                   w_tick;
    logic                   w_step;
    logic [c_OFS_W-1:0]     w_ofs_inc;
    logic [c_OFS_W-1:0]     w_ofs_dec;
    logic [c_OFS_W-1:0]     w_ofs_nxt;
    logic [LED_W-1:0]       w_rot_l;
    logic [LED_W-1:0]       w_rot_r;
    logic [LED_W-1:0]       w_leds_nxt;
    logic [c_SUM_W-1:0]     w_char_idx;
    logic [6:0]             w_char;
    logic [NUM_DIGITS-1:0]  w_an_nxt;

    assign DISP = r_disp;
    assign AN   = r_an;
    assign LEDs = r_leds;
    assign STEP = r_step;

    // The step timer free-runs; comparing with >= lets a lowered period take
    // effect on the very next cycle instead of waiting for a 32-bit wrap.
    assign w_period = SPEED ? c_TICKS_FAST : c_TICKS_SLOW;
    assign w_tick   = (r_tcnt >= (w_period - 32'd1));
    assign w_step   = w_tick & EN & ~LOAD;

    assign w_ofs_inc = (r_ofs == c_OFS_LAST) ? '0 : r_ofs + c_OFS_ONE;
    assign w_ofs_dec = (r_ofs == '0) ? c_OFS_LAST : r_ofs - c_OFS_ONE;

    generate
        if (LED_W > 1) begin : g_rot_multi
            assign w_rot_l = {r_leds[LED_W-2:0], r_leds[LED_W-1]};
            assign w_rot_r = {r_leds[0], r_leds[LED_W-1:1]};
        end else begin : g_rot_single
            assign w_rot_l = r_leds;
            assign w_rot_r = r_leds;
        end
    endgenerate

`ifdef MARQUEE_BOUNCE_EN
    typedef enum logic [0:0] {
        BDIR_UP   = 1'b0,
        BDIR_DOWN = 1'b1
    } bdir_t;

    localparam logic [c_OFS_W-1:0] c_OFS_MAX = c_OFS_W'(MSG_CHARS - NUM_DIGITS);

    bdir_t r_bdir;
    bdir_t w_bdir_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_bdir <= BDIR_UP;
        end else if (LOAD) begin
            r_bdir <= BDIR_UP;
        end else begin
            r_bdir <= w_bdir_nxt;
        end
    end
`else
    logic w_mode_unused;
    assign w_mode_unused = MODE;
`endif

    always_comb begin
        w_ofs_nxt  = r_ofs;
        w_leds_nxt = r_leds;
`ifdef MARQUEE_BOUNCE_EN
        w_bdir_nxt = r_bdir;
`endif
        if (w_step) begin
`ifdef MARQUEE_BOUNCE_EN
            if (MODE) begin
                if (r_ofs > c_OFS_MAX) begin
                    // Entering bounce from a wrap position beyond the range.
                    w_ofs_nxt  = c_OFS_MAX;
                    w_bdir_nxt = BDIR_DOWN;
                    w_leds_nxt = w_rot_r;
                end else if (c_OFS_MAX == '0) begin
                    w_leds_nxt = (r_bdir == BDIR_UP) ? w_rot_l : w_rot_r;
                    w_bdir_nxt = (r_bdir == BDIR_UP) ? BDIR_DOWN : BDIR_UP;
                end else if (r_bdir == BDIR_UP) begin
                    if (r_ofs == c_OFS_MAX) begin
                        w_bdir_nxt = BDIR_DOWN;
                        w_ofs_nxt  = w_ofs_dec;
                        w_leds_nxt = w_rot_r;
                    end else begin
                        w_ofs_nxt  = w_ofs_inc;
                        w_leds_nxt = w_rot_l;
                    end
                end else begin
                    if (r_ofs == '0) begin
                        w_bdir_nxt = BDIR_UP;
                        w_ofs_nxt  = w_ofs_inc;
                        w_leds_nxt = w_rot_l;
                    end else begin
                        w_ofs_nxt  = w_ofs_dec;
                        w_leds_nxt = w_rot_r;
                    end
                end
            end else
`endif
            begin
                w_ofs_nxt  = DIR ? w_ofs_inc : w_ofs_dec;
                w_leds_nxt = DIR ? w_rot_l : w_rot_r;
            end
        end
    end

    // Digit shown under SEL is (NUM_DIGITS-1-SEL) from the left; the sum is
    // below 2*MSG_CHARS, so one conditional subtract gives the modulo.
    always_comb begin
        w_char_idx = {1'b0, r_ofs} + c_SUM_LEFT - c_SUM_W'(r_sel);
        if (w_char_idx >= c_SUM_CHARS) begin
            w_char_idx = w_char_idx - c_SUM_CHARS;
        end
        w_char = 7'h7F;
        for (int k = 0; k < MSG_CHARS; k++) begin
            if (w_char_idx == c_SUM_W'(k)) begin
                w_char = r_msg[7*(MSG_CHARS-1-k) +: 7];
            end
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_an_nxt[k] = (r_sel != c_SEL_W'(k));
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_msg  <= MSG_INIT;
            r_ofs  <= '0;
            r_tcnt <= '0;
            r_slot <= '0;
            r_sel  <= c_SEL_LAST;
            r_an   <= '1;
            r_disp <= 7'h7F;
            r_leds <= LED_INIT;
            r_step <= 1'b0;
        end else begin
            r_an   <= w_an_nxt;
            r_disp <= w_char;

            if (r_slot == c_SLOT_LAST) begin
                r_slot <= '0;
                r_sel  <= (r_sel == '0) ? c_SEL_LAST : r_sel - c_SEL_ONE;
            end else begin
                r_slot <= r_slot + c_SLOT_ONE;
            end

            if (LOAD) begin
                r_msg  <= MSG_IN;
                r_ofs  <= '0;
                r_tcnt <= '0;
                r_leds <= LED_INIT;
                r_step <= 1'b0;
            end else begin
                r_tcnt <= w_tick ? '0 : r_tcnt + 32'd1;
                r_ofs  <= w_ofs_nxt;
                r_leds <= w_leds_nxt;
                r_step <= w_step;
            end
        end
    end

endmodule
`default_nettype wire
